// File: rtl/aes_inv_shift_rows_stream.sv
// Byte-serial AES InvShiftRows: collects a 16-byte state into one of two ping-pong
// banks and streams it back out in InvShiftRows order (byte k = state[127-8k -: 8]).
module aes_inv_shift_rows_stream (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last
);

    // Output byte index -> stored byte index: out(r,c) = in(r,(c-r) mod 4), index = 4c+r.
    function automatic logic [3:0] inv_src_idx(input logic [3:0] idx);
        logic [3:0] src;
        case (idx)
            4'd0:    src = 4'd0;
            4'd1:    src = 4'd13;
            4'd2:    src = 4'd10;
            4'd3:    src = 4'd7;
            4'd4:    src = 4'd4;
            4'd5:    src = 4'd1;
            4'd6:    src = 4'd14;
            4'd7:    src = 4'd11;
            4'd8:    src = 4'd8;
            4'd9:    src = 4'd5;
            4'd10:   src = 4'd2;
            4'd11:   src = 4'd15;
            4'd12:   src = 4'd12;
            4'd13:   src = 4'd9;
            4'd14:   src = 4'd6;
            4'd15:   src = 4'd3;
            default: src = 4'd0;
        endcase
        return src;
    endfunction

    logic [1:0][15:0][7:0] bank_q;
    logic [1:0]            full_q;
    logic [1:0]            full_d;
    logic                  wr_bank_q;
    logic                  wr_bank_d;
    logic                  rd_bank_q;
    logic                  rd_bank_d;
    logic [3:0]            wr_cnt_q;
    logic [3:0]            wr_cnt_d;
    logic [3:0]            rd_cnt_q;
    logic [3:0]            rd_cnt_d;
    logic                  wr_fire_s;
    logic                  rd_fire_s;

    // Stream-facing outputs, all taken from registered state only.
    always_comb begin
        in_ready  = ~full_q[wr_bank_q];
        out_valid = full_q[rd_bank_q];
        out_data  = bank_q[rd_bank_q][inv_src_idx(rd_cnt_q)];
        out_last  = full_q[rd_bank_q] && (rd_cnt_q == 4'd15);
        // A flush swallows any handshake presented in the same cycle.
        wr_fire_s = in_valid && ~full_q[wr_bank_q] && ~clr;
        rd_fire_s = full_q[rd_bank_q] && out_ready && ~clr;
    end

    // Next-state for counters, bank pointers and full flags.
    always_comb begin
        full_d    = full_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        wr_cnt_d  = wr_cnt_q;
        rd_cnt_d  = rd_cnt_q;
        if (clr) begin
            full_d    = 2'b00;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            wr_cnt_d  = 4'd0;
            rd_cnt_d  = 4'd0;
        end else begin
            // Set and clear always hit different banks, so both may apply.
            if (wr_fire_s) begin
                wr_cnt_d = wr_cnt_q + 4'd1;
                if (wr_cnt_q == 4'd15) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end else begin
                    wr_bank_d = wr_bank_q;
                end
            end else begin
                wr_cnt_d = wr_cnt_q;
            end
            if (rd_fire_s) begin
                rd_cnt_d = rd_cnt_q + 4'd1;
                if (rd_cnt_q == 4'd15) begin
                    full_d[rd_bank_q] = 1'b0;
                    rd_bank_d         = ~rd_bank_q;
                end else begin
                    rd_bank_d = rd_bank_q;
                end
            end else begin
                rd_cnt_d = rd_cnt_q;
            end
        end
    end

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full_q    <= 2'b00;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            wr_cnt_q  <= 4'd0;
            rd_cnt_q  <= 4'd0;
        end else begin
            full_q    <= full_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            wr_cnt_q  <= wr_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
        end
    end

    // Bank storage; only reset clears contents, a flush leaves them in place.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q <= '0;
        end else if (wr_fire_s) begin
            bank_q[wr_bank_q][wr_cnt_q] <= in_data;
        end else begin
            bank_q <= bank_q;
        end
    end

endmodule

// File: doc/aes_inv_shift_rows_stream.md
# aes_inv_shift_rows_stream

Byte-serial AES InvShiftRows unit for the decryption datapath. It accepts a 16-byte AES state one byte per cycle over a valid/ready stream and buffers it in a ping-pong pair of 128-bit banks. It then emits the InvShiftRows-permuted state byte-serially on a second valid/ready stream. Byte order matches the forward ShiftRows block: big-endian, column-major, so byte k is state bits [127-8k -: 8].

## Interface
- Parameters: none.
- clk  input  1  sole clock; all logic is rising-edge.
- rst  input  1  asynchronous, active-high reset.
- clr  input  1  synchronous flush; drops partial and buffered blocks.
- in_valid  input  1  input byte valid.
- in_ready  output  1  unit can accept a byte.
- in_data  input  8  input byte; byte index is set by the internal write count.
- out_valid  output  1  output byte valid.
- out_ready  input  1  downstream accepts the byte.
- out_data  output  8  permuted output byte.
- out_last  output  1  high with output byte index 15.

## Operation
- Storage:
  - bank[0], bank[1] are 16x8 registers.
  - full[1:0] holds one flag per bank.
  - wr_bank and rd_bank are 1-bit pointers.
  - wr_cnt and rd_cnt are 4-bit counters.
- Write side:
  - in_ready = !full[wr_bank].
  - On in_valid && in_ready: bank[wr_bank][wr_cnt] <= in_data, then wr_cnt++.
  - When wr_cnt==15: set full[wr_bank], toggle wr_bank, and wr_cnt wraps to 0.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][P(rd_cnt)].
  - out_last = out_valid && rd_cnt==15.
  - On out_valid && out_ready: rd_cnt++.
  - When rd_cnt==15: clear full[rd_bank], toggle rd_bank, and rd_cnt wraps to 0.
- Permutation P maps output index to input index, out(r,c) = in(r,(c-r) mod 4), index = 4c+r:
  - 0→0, 1→13, 2→10, 3→7
  - 4→4, 5→1, 6→14, 7→11
  - 8→8, 9→5, 10→2, 11→15
  - 12→12, 13→9, 14→6, 15→3
- Simultaneous events:
  - Set and clear of full[] in the same cycle always target different banks. Setting requires !full and clearing requires full, so both are applied.
  - A write handshake and a read handshake in the same cycle are independent.
- Full condition: both banks full gives in_ready=0 until the read side finishes a block.
- Empty condition: both flags clear gives out_valid=0.
- clr:
  - Zeroes wr_cnt, rd_cnt, wr_bank, rd_bank and full[] on the next edge.
  - Bank contents are not cleared.
  - clr overrides any handshake in the same cycle; that byte is neither stored nor counted as consumed.
- Reset: asynchronous; same effect as clr, and also zeroes both banks.

## Timing
- Reset values:
  - in_ready=1, out_valid=0, out_data=8'h00, out_last=0.
  - Counters, pointers and full[] are all 0.
- Input byte 15 accepted at edge N: out_valid=1 with output byte 0 from N.
  - Latency is one cycle from the last input handshake to first output.
  - The first output byte may come no earlier than input byte 15.
- Throughput is 1 byte/cycle sustained when in_valid and out_ready are held high. There are no bubbles between blocks.
- out_data, out_valid and out_last depend only on registered state; no combinational path from in_* to out_*.
- in_ready depends only on registered state; no combinational path from out_ready.
- Backpressure:
  - out_valid and out_data hold stable while out_ready=0.
  - Up to 32 bytes are absorbed before in_ready drops.
- Reset asserted mid-block: outputs go to their reset values immediately (asynchronously). The partial block is lost.

## Test plan
- Single block: feed 00..0F back-to-back with out_ready=1.
  - Output is 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03.
  - out_last is high only on 03.
  - First out_valid arrives the cycle after 0F is accepted.
- Streaming: 4 blocks continuously with out_ready=1 → 64 outputs in 64 consecutive cycles after initial latency, each block correctly permuted.
- Backpressure: out_ready=0 while feeding 40 bytes.
  - in_ready drops after byte 31 is accepted.
  - Releasing out_ready drains blocks 0 and 1 in order.
  - The remaining 8 bytes are then accepted.
- Flush: send 7 bytes, pulse clr together with an in_valid handshake, then send 10..1F.
  - Output is exactly the permutation of 10..1F.
  - out_valid stays 0 before the new block completes.
- Async reset: assert rst mid-output, between clock edges.
  - out_valid and out_last fall without waiting for an edge.
  - After release, in_ready=1 and a fresh block of 00..0F reproduces the single-block result.
- Round trip: random 128-bit state X through the forward ShiftRows module, serialized, through this unit, repacked → equals X for 1000 random vectors.
